// File: rtl/acc_mem_arbiter.sv
// Round-robin arbiter sharing the Data Memory accelerator port among NUM_ACC control units.
// Latency: write done 2 cycles after the request is seen in IDLE, read valid at 2+MEM_RD_LATENCY; +1 per CPU stall cycle.
// Backpressure: requests are level and held until their pulse; issue stalls while cpu_mem_en is high.
module acc_mem_arbiter #(
  parameter int NUM_ACC        = 4,
  parameter int ADDR_SIZE      = 16,
  parameter int RD_DATA_SIZE   = 512,
  parameter int WR_DATA_SIZE   = 32,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_ACC-1:0]                acc_read_en,
  input  logic [NUM_ACC*ADDR_SIZE-1:0]      acc_read_addr,
  input  logic [NUM_ACC-1:0]                acc_write_en,
  input  logic [NUM_ACC*ADDR_SIZE-1:0]      acc_write_addr,
  input  logic [NUM_ACC*WR_DATA_SIZE-1:0]   acc_write_data,
  output logic [RD_DATA_SIZE-1:0]           acc_read_data,
  output logic [NUM_ACC-1:0]                acc_read_data_valid,
  output logic [NUM_ACC-1:0]                acc_write_done,
  input  logic                              cpu_mem_en,
  output logic                              mem_en,
  output logic                              mem_wr,
  output logic [ADDR_SIZE-1:0]              mem_addr,
  output logic [WR_DATA_SIZE-1:0]           mem_wdata,
  input  logic [RD_DATA_SIZE-1:0]           mem_rdata
);

  localparam int IDX_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int CNT_W = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        gnt_idx;
  logic [IDX_W-1:0]        pick;
  logic                    any_req;
  logic                    gnt_rd;
  logic [ADDR_SIZE-1:0]    gnt_addr;
  logic [WR_DATA_SIZE-1:0] gnt_wdata;
  logic [CNT_W-1:0]        cnt;
  logic [RD_DATA_SIZE-1:0] rd_line;
  logic [NUM_ACC-1:0]      req;
  logic [NUM_ACC-1:0]      gnt_onehot;

  logic [ADDR_SIZE-1:0]    rd_addr_a [NUM_ACC];
  logic [ADDR_SIZE-1:0]    wr_addr_a [NUM_ACC];
  logic [WR_DATA_SIZE-1:0] wr_data_a [NUM_ACC];

  // Unpack the per-requester address/data buses into arrays for indexed selection.
  for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_unpack
    assign rd_addr_a[gi] = acc_read_addr[gi*ADDR_SIZE +: ADDR_SIZE];
    assign wr_addr_a[gi] = acc_write_addr[gi*ADDR_SIZE +: ADDR_SIZE];
    assign wr_data_a[gi] = acc_write_data[gi*WR_DATA_SIZE +: WR_DATA_SIZE];
  end

  assign req        = acc_read_en | acc_write_en;
  assign gnt_onehot = NUM_ACC'(1) << gnt_idx;

  // Round-robin pick: first requester at or after rr_ptr, wrapping. Scanning from the far end
  // lets the nearest candidate overwrite earlier ones.
  always_comb begin
    int j;
    j       = 0;
    pick    = '0;
    any_req = 1'b0;
    for (int k = NUM_ACC - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_ACC) j = j - NUM_ACC;
      if (req[IDX_W'(j)]) begin
        pick    = IDX_W'(j);
        any_req = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and memory/response strobes; everything forced low while reset is asserted
  // so an aborted transaction never leaks a strobe or pulse.
  always_comb begin
    state_nx            = state;
    mem_en              = 1'b0;
    mem_wr              = 1'b0;
    mem_addr            = '0;
    mem_wdata           = '0;
    acc_read_data_valid = '0;
    acc_write_done      = '0;
    case (state)
      IDLE: begin
        if (any_req) state_nx = ISSUE;
      end
      ISSUE: begin
        if (!cpu_mem_en) begin
          mem_en    = 1'b1;
          mem_wr    = !gnt_rd;
          mem_addr  = gnt_addr;
          mem_wdata = gnt_rd ? '0 : gnt_wdata;
          state_nx  = gnt_rd ? WAIT_RD : RESPOND;
        end
      end
      WAIT_RD: begin
        if (cnt == '0) state_nx = RESPOND;
      end
      RESPOND: begin
        if (gnt_rd) acc_read_data_valid = gnt_onehot;
        else        acc_write_done      = gnt_onehot;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!rst_n) begin
      mem_en              = 1'b0;
      mem_wr              = 1'b0;
      mem_addr            = '0;
      mem_wdata           = '0;
      acc_read_data_valid = '0;
      acc_write_done      = '0;
    end
  end

  // Grant latch, read-latency countdown and round-robin pointer advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      gnt_rd    <= 1'b0;
      gnt_addr  <= '0;
      gnt_wdata <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_idx   <= pick;
            // Read wins when both enables are up; the write waits for a later grant.
            gnt_rd    <= acc_read_en[pick];
            gnt_addr  <= acc_read_en[pick] ? rd_addr_a[pick] : wr_addr_a[pick];
            gnt_wdata <= wr_data_a[pick];
          end
        end
        ISSUE: begin
          if (!cpu_mem_en && gnt_rd) cnt <= CNT_W'(MEM_RD_LATENCY - 1);
        end
        WAIT_RD: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        RESPOND: begin
          rr_ptr <= (gnt_idx == IDX_W'(NUM_ACC - 1)) ? '0 : gnt_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read line capture on the last WAIT_RD cycle; held until the next capture.
  always_ff @(posedge clk) begin
    if (!rst_n)                             rd_line <= '0;
    else if (state == WAIT_RD && cnt == '0) rd_line <= mem_rdata;
  end

  assign acc_read_data = rst_n ? rd_line : '0;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Randomized scoreboard bench for acc_mem_arbiter against a transaction-level reference model.
// Latency: expected events carry their cycle number; the monitor checks exact timing.
// Backpressure: random CPU stalls and level-held requests from NUM_ACC random agents.
module tb_acc_mem_arbiter;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int RW  = 512;
  localparam int WW  = 32;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      acc_read_en, acc_write_en;
  logic [N*AW-1:0]   acc_read_addr, acc_write_addr;
  logic [N*WW-1:0]   acc_write_data;
  logic [RW-1:0]     acc_read_data;
  logic [N-1:0]      acc_read_data_valid, acc_write_done;
  logic              cpu_mem_en, mem_en, mem_wr;
  logic [AW-1:0]     mem_addr;
  logic [WW-1:0]     mem_wdata;
  logic [RW-1:0]     mem_rdata;

  acc_mem_arbiter #(
    .NUM_ACC(N), .ADDR_SIZE(AW), .RD_DATA_SIZE(RW), .WR_DATA_SIZE(WW), .MEM_RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .acc_read_en(acc_read_en), .acc_read_addr(acc_read_addr),
    .acc_write_en(acc_write_en), .acc_write_addr(acc_write_addr),
    .acc_write_data(acc_write_data), .acc_read_data(acc_read_data),
    .acc_read_data_valid(acc_read_data_valid), .acc_write_done(acc_write_done),
    .cpu_mem_en(cpu_mem_en), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct { int c; bit wr; logic [AW-1:0] addr; logic [WW-1:0] data; } iss_t;
  typedef struct { int c; int idx; bit rd; logic [RW-1:0] data; } rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  // Agent state: what each requester currently holds.
  bit          rd_pend [N];
  bit          wr_pend [N];
  logic [AW-1:0] ra [N];
  logic [AW-1:0] wa [N];
  logic [WW-1:0] wd [N];
  int          seen_rd [N];
  int          seen_wr [N];
  int          ack_rd  [N];
  int          ack_wr  [N];
  int unsigned req_pct, rd_pct, wr_pct, cpu_pct;
  bit          stop_new;

  // Reference model state.
  int ph = 0;
  int rr = 0;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock of stimulus: retire served requests, maybe start new ones, randomize CPU and memory.
  task automatic drive_cycle(input bit rst_val);
    @(posedge clk);
    #1;
    rst_n = rst_val;
    for (int i = 0; i < N; i++) begin
      if (seen_rd[i] != ack_rd[i]) begin ack_rd[i] = seen_rd[i]; rd_pend[i] = 1'b0; end
      if (seen_wr[i] != ack_wr[i]) begin ack_wr[i] = seen_wr[i]; wr_pend[i] = 1'b0; end
      if (!stop_new && !rd_pend[i] && !wr_pend[i] && $urandom_range(99) < req_pct) begin
        rd_pend[i] = ($urandom_range(99) < rd_pct);
        wr_pend[i] = ($urandom_range(99) < wr_pct);
        ra[i] = AW'($urandom);
        wa[i] = AW'($urandom);
        wd[i] = $urandom;
      end
      acc_read_en[i]              = rd_pend[i];
      acc_write_en[i]             = wr_pend[i];
      acc_read_addr[i*AW +: AW]   = ra[i];
      acc_write_addr[i*AW +: AW]  = wa[i];
      acc_write_data[i*WW +: WW]  = wd[i];
    end
    cpu_mem_en = ($urandom_range(99) < cpu_pct);
    for (int k = 0; k < RW / 32; k++) mem_rdata[k*32 +: 32] = $urandom;
  endtask

  function automatic int pend_count();
    int n;
    n = 0;
    for (int i = 0; i < N; i++) n += int'(rd_pend[i]) + int'(wr_pend[i]);
    return n;
  endfunction

  // Reference model: transaction timeline derived from the arbitration and latency rules.
  // ph 0 = free, 1 = granted awaiting issue, 2 = read in flight, 3 = response cycle pending.
  initial begin : model
    int w;
    int m_idx, cap_cyc, resp_cyc;
    bit m_rd;
    logic [AW-1:0] m_addr;
    logic [WW-1:0] m_data;
    m_idx = 0; cap_cyc = 0; resp_cyc = 0; m_rd = 1'b0; m_addr = '0; m_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        ph = 0;
        rr = 0;
        iss_q.delete();
        rsp_q.delete();
      end else begin
        case (ph)
          0: begin
            w = -1;
            for (int k = 0; k < N; k++) begin
              int j;
              j = (rr + k) % N;
              if (w < 0 && (rd_pend[j] || wr_pend[j])) w = j;
            end
            if (w >= 0) begin
              m_idx  = w;
              m_rd   = rd_pend[w];
              m_addr = m_rd ? ra[w] : wa[w];
              m_data = wd[w];
              ph     = 1;
            end
          end
          1: begin
            if (!cpu_mem_en) begin
              iss_q.push_back('{c: cyc, wr: !m_rd, addr: m_addr, data: m_data});
              if (m_rd) begin
                cap_cyc = cyc + LAT;
                ph      = 2;
              end else begin
                rsp_q.push_back('{c: cyc + 1, idx: m_idx, rd: 1'b0, data: '0});
                resp_cyc = cyc + 1;
                ph       = 3;
              end
            end
          end
          2: begin
            if (cyc == cap_cyc) begin
              rsp_q.push_back('{c: cyc + 1, idx: m_idx, rd: 1'b1, data: mem_rdata});
              resp_cyc = cyc + 1;
              ph       = 3;
            end
          end
          default: begin
            if (cyc == resp_cyc) begin
              rr = (m_idx + 1) % N;
              ph = 0;
            end
          end
        endcase
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the head of the expectation queues.
  initial begin : monitor
    iss_t e;
    rsp_t r;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_mem_en", RW'(mem_en), RW'(0));
        chk("rst_pulses", RW'({acc_read_data_valid, acc_write_done}), RW'(0));
        chk("rst_read_data", acc_read_data, '0);
      end else begin
        while (iss_q.size() > 0 && iss_q[0].c < cyc) begin
          e = iss_q.pop_front();
          chk("issue_missing_cycle", RW'(cyc), RW'(e.c));
        end
        while (rsp_q.size() > 0 && rsp_q[0].c < cyc) begin
          r = rsp_q.pop_front();
          chk("response_missing_cycle", RW'(cyc), RW'(r.c));
        end
        if (mem_en) begin
          if (iss_q.size() == 0) begin
            chk("unexpected_mem_en", RW'(mem_en), RW'(0));
          end else begin
            e = iss_q.pop_front();
            chk("issue_cycle", RW'(cyc), RW'(e.c));
            chk("issue_wr", RW'(mem_wr), RW'(e.wr));
            chk("issue_addr", RW'(mem_addr), RW'(e.addr));
            if (e.wr) chk("issue_wdata", RW'(mem_wdata), RW'(e.data));
          end
        end else begin
          chk("idle_mem_bus", RW'({mem_wr, mem_addr, mem_wdata}), RW'(0));
        end
        if (|acc_read_data_valid || |acc_write_done) begin
          for (int i = 0; i < N; i++) begin
            if (acc_read_data_valid[i]) seen_rd[i]++;
            if (acc_write_done[i])      seen_wr[i]++;
          end
          if (rsp_q.size() == 0) begin
            chk("unexpected_pulse", RW'({acc_read_data_valid, acc_write_done}), RW'(0));
          end else begin
            r = rsp_q.pop_front();
            oh = '0;
            oh[r.idx] = 1'b1;
            chk("resp_cycle", RW'(cyc), RW'(r.c));
            chk("resp_valid", RW'(acc_read_data_valid), r.rd ? RW'(oh) : RW'(0));
            chk("resp_done", RW'(acc_write_done), r.rd ? RW'(0) : RW'(oh));
            if (r.rd) chk("resp_read_data", acc_read_data, r.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach its end (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    rst_n = 1'b0;
    cpu_mem_en = 1'b0;
    acc_read_en = '0; acc_write_en = '0;
    acc_read_addr = '0; acc_write_addr = '0; acc_write_data = '0;
    mem_rdata = '0;
    for (int i = 0; i < N; i++) begin
      rd_pend[i] = 1'b0; wr_pend[i] = 1'b0; ra[i] = '0; wa[i] = '0; wd[i] = '0;
      seen_rd[i] = 0; seen_wr[i] = 0; ack_rd[i] = 0; ack_wr[i] = 0;
    end
    stop_new = 1'b1;
    req_pct = 0; rd_pct = 0; wr_pct = 0; cpu_pct = 0;
    repeat (3) drive_cycle(1'b0);

    // All requesters hold writes from reset: strict 0,1,2,3 rotation every 3 cycles.
    stop_new = 1'b0; req_pct = 100; rd_pct = 0; wr_pct = 100; cpu_pct = 0;
    repeat (40) drive_cycle(1'b1);

    // Mixed reads/writes (including both at once) with light CPU contention.
    req_pct = 30; rd_pct = 60; wr_pct = 60; cpu_pct = 20;
    repeat (600) drive_cycle(1'b1);

    // Heavy CPU contention stretches the issue cycle.
    req_pct = 50; cpu_pct = 70;
    repeat (200) drive_cycle(1'b1);

    // Reset while a read is in flight: no pulse, and the next grant restarts at requester 0.
    req_pct = 60; rd_pct = 100; wr_pct = 30; cpu_pct = 10;
    n = 0;
    while (ph != 2 && n < 300) begin
      drive_cycle(1'b1);
      #2;
      n++;
    end
    chk("reached_read_in_flight", RW'(ph), RW'(2));
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    rd_pct = 60; wr_pct = 60; cpu_pct = 25; req_pct = 40;
    repeat (300) drive_cycle(1'b1);

    // Drain outstanding work.
    stop_new = 1'b1;
    n = 0;
    while (n < 300 && (pend_count() != 0 || iss_q.size() != 0 || rsp_q.size() != 0)) begin
      drive_cycle(1'b1);
      n++;
    end
    repeat (5) drive_cycle(1'b1);
    chk("drain_pending", RW'(pend_count()), RW'(0));
    chk("drain_queues", RW'(iss_q.size() + rsp_q.size()), RW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
